accel_watchdog: RTL and testbench

Parametrised, synthesizable multi-channel watchdog that supervises accelerator operations and produces a single pass/fail verdict. Each channel runs a reloadable timeout counter that is armed by a global start, refreshed by activity kicks and stopped by a per-channel done. The block sits beside the accelerator controller and replaces per-testbench timeout traps with an in-fabric monitor. Its status is readable by the host and by the bench.

---
 rtl/accel_wdt_pkg.sv | 15 +
 rtl/accel_watchdog_if.sv | 26 ++
 rtl/accel_wdt_channel.sv | 37 +++
 rtl/accel_watchdog.sv | 83 ++++++++
 tb/tb_accel_watchdog.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/accel_wdt_pkg.sv
// accel_wdt_pkg: shared state type and default sizing for the accelerator watchdog
package accel_wdt_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_PRESCALE = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN = ST_RUN,
    DONE = ST_DONE,
    EXPIRED = ST_EXPIRED
  } wdt_state_e;
endpackage

// File: rtl/accel_watchdog_if.sv
// accel_watchdog_if: control/status bundle between accelerator controller and watchdog
interface accel_watchdog_if
  import accel_wdt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int ID_W = N_CH > 1 ? $clog2(N_CH) : 1;
  logic start;
  logic [N_CH*CNT_W-1:0] timeout_val;
  logic [N_CH-1:0] kick;
  logic [N_CH-1:0] done;
  logic busy;
  logic [N_CH-1:0] expired;
  logic status_valid;
  logic status_pass;
  logic [ID_W-1:0] first_expired_id;
  modport master (
    output start, timeout_val, kick, done,
    input busy, expired, status_valid, status_pass, first_expired_id
  );
  modport slave (
    input start, timeout_val, kick, done,
    output busy, expired, status_valid, status_pass, first_expired_id
  );
endinterface

// File: rtl/accel_wdt_channel.sv
// accel_wdt_channel: one supervised channel, FSM plus reloadable timeout counter
module accel_wdt_channel
  import accel_wdt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             kick,
  input  logic             done,
  input  logic [CNT_W-1:0] timeout_val,
  output wdt_state_e       state,
  output logic             expire_pulse
);
  logic [CNT_W-1:0] cnt;
  logic run;
  assign run = state == RUN;
  assign expire_pulse = run & ~done & ~kick & tick & (cnt == '0);
  // done beats kick beats expiry; a sibling's abort only lands if this channel is otherwise idle-ticking
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else if (start) begin
      state <= RUN;
      cnt <= timeout_val;
    end else if (run) begin
      if (done) state <= DONE;
      else if (kick) cnt <= timeout_val;
      else if (expire_pulse) state <= EXPIRED;
      else if (abort) state <= IDLE;
      else if (tick) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/accel_watchdog.sv
// accel_watchdog: multi-channel watchdog with a single pass/fail verdict; ACCEL_WDT_PRESCALE_EN enables the shared tick prescaler
module accel_watchdog
  import accel_wdt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FAIL_FAST = 1,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input logic clk,
  input logic rst_n,
  accel_watchdog_if.slave bus
);
  localparam int ID_W = N_CH > 1 ? $clog2(N_CH) : 1;
  wdt_state_e st [N_CH];
  logic [N_CH-1:0] run, expd, pulse;
  logic tick, accept, abort, any_run, armed, busy_q, valid_q, pass_q;
  logic [ID_W-1:0] first_id, enc;
  assign any_run = |run;
  // busy_q lags the channel states by one edge, so both gate a new start
  assign accept = bus.start & ~any_run & ~busy_q;
  assign abort = (FAIL_FAST != 0) & |pulse;
`ifdef ACCEL_WDT_PRESCALE_EN
  localparam int PRE_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PRE_W-1:0] pre;
  assign tick = pre == PRE_W'(PRESCALE - 1);
  always_ff @(posedge clk)
    if (!rst_n || accept) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = 1'b1;
`endif
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    accel_wdt_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .start(accept),
      .abort(abort),
      .kick(bus.kick[i]),
      .done(bus.done[i]),
      .timeout_val(bus.timeout_val[i*CNT_W +: CNT_W]),
      .state(st[i]),
      .expire_pulse(pulse[i])
    );
    assign run[i] = st[i] == RUN;
    assign expd[i] = st[i] == EXPIRED;
  end
  always_comb begin
    enc = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (pulse[i]) enc = ID_W'(i);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      armed <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      pass_q <= 1'b0;
      first_id <= '0;
    end else begin
      busy_q <= any_run;
      if (accept) begin
        armed <= 1'b1;
        valid_q <= 1'b0;
        pass_q <= 1'b0;
        first_id <= '0;
      end else begin
        if (armed && !any_run) begin
          armed <= 1'b0;
          valid_q <= 1'b1;
          pass_q <= ~|expd;
        end
        if (|pulse && !(|expd)) first_id <= enc;
      end
    end
  assign bus.busy = busy_q;
  assign bus.expired = expd;
  assign bus.status_valid = valid_q;
  assign bus.status_pass = pass_q;
  assign bus.first_expired_id = first_id;
endmodule

// File: tb/tb_accel_watchdog.sv
// tb_accel_watchdog: directed self-checking bench for accel_watchdog
module tb_accel_watchdog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  accel_watchdog_if #(.N_CH(4), .CNT_W(16)) bus ();
  accel_watchdog #(.N_CH(4), .CNT_W(16), .FAIL_FAST(1), .PRESCALE(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_tv(input logic [15:0] a, b, c, d);
    bus.timeout_val = {d, c, b, a};
  endtask
  task automatic go();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.kick = '0;
    bus.done = '0;
    bus.timeout_val = '0;
    cyc(2);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_exp", 32'(bus.expired), 0);
    check("rst_valid", 32'(bus.status_valid), 0);
    check("rst_pass", 32'(bus.status_pass), 0);
    check("rst_id", 32'(bus.first_expired_id), 0);
    rst_n = 1'b1;
    cyc(1);
`ifdef ACCEL_WDT_PRESCALE_EN
    set_tv(2, 2, 2, 2);
    go();
    cyc(23);
    check("pre_e23", 32'(bus.expired), 0);
    cyc(1);
    check("pre_e24", 32'(bus.expired), 32'hf);
    cyc(1);
    check("pre_valid", 32'(bus.status_valid), 1);
    check("pre_pass", 32'(bus.status_pass), 0);
`else
    set_tv(3, 3, 3, 3);
    go();
    check("t1_busy_e0", 32'(bus.busy), 0);
    cyc(1);
    check("t1_busy_e1", 32'(bus.busy), 1);
    bus.done = '1;
    cyc(1);
    bus.done = '0;
    check("t1_valid_e2", 32'(bus.status_valid), 0);
    cyc(1);
    check("t1_valid", 32'(bus.status_valid), 1);
    check("t1_pass", 32'(bus.status_pass), 1);
    check("t1_exp", 32'(bus.expired), 0);
    check("t1_busy", 32'(bus.busy), 0);
    set_tv(100, 100, 3, 100);
    go();
    cyc(3);
    check("t2_exp_e3", 32'(bus.expired), 0);
    cyc(1);
    check("t2_exp_e4", 32'(bus.expired), 32'h4);
    check("t2_id", 32'(bus.first_expired_id), 2);
    check("t2_busy_e4", 32'(bus.busy), 1);
    check("t2_valid_e4", 32'(bus.status_valid), 0);
    cyc(1);
    check("t2_valid", 32'(bus.status_valid), 1);
    check("t2_pass", 32'(bus.status_pass), 0);
    check("t2_busy", 32'(bus.busy), 0);
    check("t2_exp_ff", 32'(bus.expired), 32'h4);
    set_tv(5, 100, 100, 100);
    go();
    check("t3_clr_exp", 32'(bus.expired), 0);
    check("t3_clr_valid", 32'(bus.status_valid), 0);
    check("t3_clr_id", 32'(bus.first_expired_id), 0);
    cyc(2);
    bus.kick = 4'b0001;
    cyc(1);
    bus.kick = '0;
    cyc(3);
    bus.kick = 4'b0001;
    cyc(1);
    bus.kick = '0;
    cyc(5);
    check("t3_exp_e12", 32'(bus.expired), 0);
    cyc(1);
    check("t3_exp_e13", 32'(bus.expired), 32'h1);
    check("t3_id", 32'(bus.first_expired_id), 0);
    cyc(1);
    check("t3_valid", 32'(bus.status_valid), 1);
    set_tv(50, 2, 50, 2);
    go();
    cyc(2);
    check("t4_exp_e2", 32'(bus.expired), 0);
    cyc(1);
    check("t4_exp_e3", 32'(bus.expired), 32'ha);
    check("t4_id", 32'(bus.first_expired_id), 1);
    cyc(1);
    check("t4_pass", 32'(bus.status_pass), 0);
    set_tv(2, 2, 2, 2);
    go();
    cyc(2);
    bus.done = '1;
    cyc(1);
    bus.done = '0;
    check("t5_done_exp", 32'(bus.expired), 0);
    cyc(1);
    check("t5_done_valid", 32'(bus.status_valid), 1);
    check("t5_done_pass", 32'(bus.status_pass), 1);
    set_tv(4, 4, 4, 4);
    go();
    bus.start = 1'b1;
    set_tv(0, 0, 0, 0);
    cyc(2);
    bus.start = 1'b0;
    check("t5_ign_e2", 32'(bus.expired), 0);
    check("t5_ign_busy", 32'(bus.busy), 1);
    cyc(2);
    check("t5_ign_e4", 32'(bus.expired), 0);
    cyc(1);
    check("t5_ign_e5", 32'(bus.expired), 32'hf);
    check("t5_ign_id", 32'(bus.first_expired_id), 0);
    cyc(1);
    check("t5_ign_valid", 32'(bus.status_valid), 1);
    set_tv(10, 10, 10, 10);
    go();
    cyc(3);
    check("t6_busy_pre", 32'(bus.busy), 1);
    rst_n = 1'b0;
    cyc(1);
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_exp", 32'(bus.expired), 0);
    check("t6_valid", 32'(bus.status_valid), 0);
    check("t6_pass", 32'(bus.status_pass), 0);
    rst_n = 1'b1;
    cyc(15);
    check("t6_exp_late", 32'(bus.expired), 0);
    check("t6_valid_late", 32'(bus.status_valid), 0);
    check("t6_busy_late", 32'(bus.busy), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
